// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, 1 start bit, 8 data bits LSB-first,
// optional parity bit, 1 stop bit, one serial bit per CLK cycle.
// Optional feature macro: UART_TX_HOLD_REG_EN adds a one-entry holding
// register so the next byte can be accepted while a frame is on the line.
module uart_tx_frame (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic       ready,
    output logic       TX_OUT,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] data_r;
    logic       par_en_r, par_typ_r;
    logic       tx_nxt;
    logic       accept;
    logic       load_frame;   // accepted byte goes straight into the frame registers
    logic       drain;        // held byte moves into the frame registers

    assign accept = Data_Valid && ready;

`ifdef UART_TX_HOLD_REG_EN
    logic [7:0] hold_data;
    logic       hold_par_en, hold_par_typ, hold_full;

    assign ready      = !hold_full;
    assign drain      = (state == STOP) && hold_full;
    // A byte accepted while idle, or on the edge that ends an undrained stop
    // bit, starts immediately; anything else waits in the hold register.
    assign load_frame = accept && ((state == IDLE) || (state == STOP));

    // Holding register: filled by a mid-frame accept, emptied at stop-bit end.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_data    <= 8'h00;
            hold_par_en  <= 1'b0;
            hold_par_typ <= 1'b0;
            hold_full    <= 1'b0;
        end else if (accept && !load_frame) begin
            hold_data    <= P_DATA;
            hold_par_en  <= PAR_EN;
            hold_par_typ <= PAR_TYP;
            hold_full    <= 1'b1;
        end else if (drain) begin
            hold_full    <= 1'b0;
        end
    end

    // Frame registers: loaded from the inputs or from the hold register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_r    <= 8'h00;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else if (load_frame) begin
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
        end else if (drain) begin
            data_r    <= hold_data;
            par_en_r  <= hold_par_en;
            par_typ_r <= hold_par_typ;
        end
    end
`else
    // ready mirrors the registered busy flag, so an accept only happens in IDLE.
    assign ready      = !busy;
    assign drain      = 1'b0;
    assign load_frame = accept;

    // Frame registers: latched on accept so the frame ignores later input changes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_r    <= 8'h00;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else if (load_frame) begin
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
        end
    end
`endif

    // State register plus registered line and busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            idx    <= 3'd0;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            TX_OUT <= tx_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

    // Next state, bit index and the line level for the state being entered.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (load_frame) state_nxt = START;
            end
            START: begin
                state_nxt = DATA;
                idx_nxt   = 3'd0;
            end
            DATA: begin
                idx_nxt = idx + 3'd1;
                if (idx == 3'd7) state_nxt = par_en_r ? PARITY : STOP;
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                state_nxt = (load_frame || drain) ? START : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // The line is driven from a flop, so compute the level of the next state.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_r[idx_nxt];
            PARITY:  tx_nxt = (^data_r) ^ par_typ_r;
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule
